// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for seq_divider.
// master drives operands and start; slave (the divider) returns status and results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to add two's-complement division selected by signed_op.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    seq_divider_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_out_q, dbz_out_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             accept;
    logic             div0;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // busy_q also covers the done cycle, so a start there is dropped.
    assign accept = bus.start && !busy_q && (state_q == StIdle);
    assign div0   = (bus.divisor == '0);

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_quo_q, neg_rem_q;

    assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor : bus.divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end
    end

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.signed_op;
    assign a_mag            = bus.dividend;
    assign b_mag            = bus.divisor;
    assign quo_fix          = quo_q;
    assign rem_fix          = rem_q;
`endif

    // Shift-in value is WIDTH+1 bits wide so the compare holds with divisor MSB set;
    // the difference itself always fits in WIDTH bits when it is kept.
    assign partial = {rem_q, dvnd_q[WIDTH-1]};
    assign ge      = partial >= {1'b0, dvsr_q};
    assign diff    = partial[WIDTH-1:0] - dvsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            dvnd_q      <= '0;
            dvsr_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_out_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            dvnd_q      <= dvnd_d;
            dvsr_q      <= dvsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_out_q   <= dbz_out_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = div0 ? StFinish : StCalc;
            StCalc:   if (cnt_q == CNT_W'(1)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        dvnd_d      = dvnd_q;
        dvsr_d      = dvsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        dbz_d       = dbz_q;
        busy_d      = done_q ? 1'b0 : busy_q;
        done_d      = 1'b0;
        dbz_out_d   = dbz_out_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Raw dividend is kept on divide-by-zero: it becomes the remainder.
                    dvnd_d      = div0 ? bus.dividend : a_mag;
                    dvsr_d      = b_mag;
                    rem_d       = '0;
                    quo_d       = '0;
                    cnt_d       = CNT_W'(WIDTH);
                    dbz_d       = div0;
                    busy_d      = 1'b1;
                    dbz_out_d   = 1'b0;
                    quotient_d  = '0;
                    remainder_d = '0;
                end
            end
            StCalc: begin
                dvnd_d = dvnd_q << 1;
                rem_d  = ge ? diff : partial[WIDTH-1:0];
                quo_d  = {quo_q[WIDTH-2:0], ge};
                cnt_d  = cnt_q - CNT_W'(1);
            end
            StFinish: begin
                done_d = 1'b1;
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvnd_q;
                    dbz_out_d   = 1'b1;
                end else begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dbz_out_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an 8-bit and a 32-bit instance checked against
// plain-arithmetic division, including latency, divide-by-zero and signed cases.
module tb_seq_divider;
`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8))  if8 ();
    seq_divider_if #(.WIDTH(32)) if32 ();

    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] dbz;
        int unsigned t_done;
    } exp_t;

    exp_t        sb8[$];
    exp_t        sb32[$];
    exp_t        m8, m32;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                   input int w, input bit sgn);
        exp_t            e;
        longint unsigned m;
        longint          sa, sb;
        m     = (64'd1 << w) - 64'd1;
        e.dbz = 32'd0;
        e.t_done = 0;
        if (b == 0) begin
            e.q   = 32'(m);
            e.r   = 32'(a);
            e.dbz = 32'd1;
        end else if (sgn && SignedEn) begin
            sa  = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - longint'(64'd1 << w)
                                                : longint'(a);
            sb  = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - longint'(64'd1 << w)
                                                : longint'(b);
            e.q = 32'((sa / sb) & longint'(m));
            e.r = 32'((sa % sb) & longint'(m));
        end else begin
            e.q = 32'(a / b);
            e.r = 32'(a % b);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && if8.done) begin
            if (sb8.size() == 0) fail("dut8 done", "done=1 with no division outstanding");
            else begin
                m8 = sb8.pop_front();
                chk("dut8 quotient", 32'(if8.quotient), m8.q);
                chk("dut8 remainder", 32'(if8.remainder), m8.r);
                chk("dut8 div_by_zero", 32'(if8.div_by_zero), m8.dbz);
                chk("dut8 done cycle", cyc, m8.t_done);
            end
        end
        if (!reset && if32.done) begin
            if (sb32.size() == 0) fail("dut32 done", "done=1 with no division outstanding");
            else begin
                m32 = sb32.pop_front();
                chk("dut32 quotient", if32.quotient, m32.q);
                chk("dut32 remainder", if32.remainder, m32.r);
                chk("dut32 div_by_zero", 32'(if32.div_by_zero), m32.dbz);
                chk("dut32 done cycle", cyc, m32.t_done);
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit push);
        exp_t e;
        int   n = 0;
        while (if8.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail("dut8 idle wait", "busy stayed high for 100 cycles");
        if8.dividend  = a;
        if8.divisor   = b;
        if8.signed_op = s;
        if8.start     = 1'b1;
        tick();
        if8.start = 1'b0;
        chk("dut8 busy after start", 32'(if8.busy), 32'd1);
        if (push) begin
            e        = model(64'(a), 64'(b), 8, s);
            e.t_done = cyc + ((b == 8'd0) ? 1 : 9);
            sb8.push_back(e);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t e;
        int   n = 0;
        while (if32.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail("dut32 idle wait", "busy stayed high for 100 cycles");
        if32.dividend  = a;
        if32.divisor   = b;
        if32.signed_op = s;
        if32.start     = 1'b1;
        tick();
        if32.start = 1'b0;
        chk("dut32 busy after start", 32'(if32.busy), 32'd1);
        e        = model(64'(a), 64'(b), 32, s);
        e.t_done = cyc + ((b == 32'd0) ? 1 : 33);
        sb32.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb8.size() != 0 || sb32.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("scoreboard drained", 32'(sb8.size() + sb32.size()), 32'd0);
    endtask

    task automatic chk_zero8(input string tag);
        chk({tag, " busy"}, 32'(if8.busy), 32'd0);
        chk({tag, " done"}, 32'(if8.done), 32'd0);
        chk({tag, " div_by_zero"}, 32'(if8.div_by_zero), 32'd0);
        chk({tag, " quotient"}, 32'(if8.quotient), 32'd0);
        chk({tag, " remainder"}, 32'(if8.remainder), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          n;
        if8.start  = 1'b0; if8.signed_op  = 1'b0; if8.dividend  = '0; if8.divisor  = '0;
        if32.start = 1'b0; if32.signed_op = 1'b0; if32.dividend = '0; if32.divisor = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_zero8("reset dut8");
        chk("reset dut32 busy", 32'(if32.busy), 32'd0);
        chk("reset dut32 quotient", if32.quotient, 32'd0);

        issue32(32'd100, 32'd7, 1'b0);
        issue32(32'd55, 32'd0, 1'b0);
        issue32(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2, 3: b = 32'($urandom_range(1, 255));
                4:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            issue32(a, b, 1'($urandom_range(0, 1)));
        end
        drain();

        issue8(8'hFF, 8'h80, 1'b0, 1'b1);
        issue8(8'hF9, 8'h02, 1'b1, 1'b1);
        issue8(8'h80, 8'hFF, 1'b1, 1'b1);
        issue8(8'h37, 8'h00, 1'b1, 1'b1);
        issue8(8'hF9, 8'h02, 1'b0, 1'b1);

        // Starts while busy and in the done cycle must be dropped.
        issue8(8'd100, 8'd7, 1'b0, 1'b1);
        repeat (3) tick();
        if8.dividend = 8'd200; if8.divisor = 8'd3; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        n = 0;
        while (if8.done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail("dut8 done wait", "no done within 50 cycles");
        if8.dividend = 8'd9; if8.divisor = 8'd9; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        repeat (12) tick();
        drain();

        // Reset in the middle of a calculation.
        issue8(8'hC8, 8'h03, 1'b0, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero8("mid-calc reset dut8");
        issue8(8'hC8, 8'h03, 1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case ($urandom_range(0, 15))
                0:       b = 32'd0;
                1, 2:    b = 32'd1;
                3, 4, 5: b = 32'($urandom_range(1, 15));
                6:       b = 32'h80 | 32'($urandom_range(0, 127));
                default: b = $urandom;
            endcase
            issue8(a[7:0], b[7:0], 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        repeat (3) tick();
        chk("final dut8 busy", 32'(if8.busy), 32'd0);
        chk("final dut32 busy", 32'(if32.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
